// File: rtl/mem_mc_pkg.sv
// Shared constants, channel-ID width helper and read-pipeline stage type for mem_mc_arb.
package mem_mc_pkg;

  localparam int DEF_WIDTH      = 32'sd16;
  localparam int DEF_ADDR_WIDTH = 32'sd4;
  localparam int DEF_NUM_CH     = 32'sd2;
  localparam int DEF_RD_LAT     = 32'sd1;

  // Stage fields are sized for the widest supported configuration; users slice down.
  localparam int MAX_WIDTH = 32'sd64;
  localparam int MAX_CH_W  = 32'sd8;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 32'sd1) ? $clog2(num_ch) : 32'sd1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [MAX_CH_W-1:0]  ch;
    logic [MAX_WIDTH-1:0] data;
  } rd_stage_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from rr_ptr, pointer advances past each winner.
module mem_rr_arbiter
  import mem_mc_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int CH_W  = ch_w(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] valid_i,
  input  logic              hs_i,
  output logic [NUM_CH-1:0] ready_o,
  output logic [CH_W-1:0]   gnt_idx_o
);

  logic [CH_W-1:0] rr_ptr_q;
  logic [CH_W-1:0] rr_ptr_d;
  logic [CH_W:0]   sum_s;
  logic [CH_W-1:0] idx_s;
  logic            found_s;
  logic            hit_s;

  // Rotating-priority search; grants are suppressed while reset is held.
  always_comb begin
    ready_o   = '0;
    gnt_idx_o = '0;
    found_s   = 1'b0;
    sum_s     = '0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_s          = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      sum_s          = (sum_s >= (CH_W+1)'(NUM_CH)) ? sum_s - (CH_W+1)'(NUM_CH) : sum_s;
      idx_s          = sum_s[CH_W-1:0];
      hit_s          = !found_s && valid_i[idx_s] && rst_i;
      ready_o[idx_s] = ready_o[idx_s] | hit_s;
      gnt_idx_o      = hit_s ? idx_s : gnt_idx_o;
      found_s        = found_s | hit_s;
    end
  end

  // Next pointer: one past the winner, wrapping at NUM_CH.
  always_comb begin
    if (hs_i) begin
      rr_ptr_d = (gnt_idx_o == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_o + CH_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/mem_mc_arb.sv
// Multi-channel round-robin front end to a single-port RAM with tagged, pipelined read responses.
// Optional byte strobes on writes when MEM_WSTRB_EN is defined.
module mem_mc_arb
  import mem_mc_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int RD_LAT     = DEF_RD_LAT,
  localparam int CH_W      = ch_w(NUM_CH),
  localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            valid_i,
  input  logic [NUM_CH-1:0]            wr_rd_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_CH*WIDTH-1:0]      wdata_i,
`ifdef MEM_WSTRB_EN
  input  logic [NUM_CH*(WIDTH/8)-1:0]  wstrb_i,
`endif
  output logic [NUM_CH-1:0]            ready_o,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         rvalid_o,
  output logic [CH_W-1:0]              rch_o
);

  logic [NUM_CH-1:0]     ready_s;
  logic [CH_W-1:0]       gnt_idx_s;
  logic                  hs_s;
  logic                  wr_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [WIDTH-1:0]      wdata_s;
  logic [WIDTH-1:0]      wmask_s;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  rd_stage_t             pipe_q [RD_LAT];
  logic                  unused_s;

  mem_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .hs_i      (hs_s),
    .ready_o   (ready_s),
    .gnt_idx_o (gnt_idx_s)
  );

  assign ready_o = ready_s;
  assign hs_s    = |(valid_i & ready_s);
  assign wr_en_s = hs_s & wr_s;
  assign rd_en_s = hs_s & ~wr_s;

  // Select the granted channel's request; ready is one-hot so OR-merging is exact.
  always_comb begin
    wr_s    = 1'b0;
    addr_s  = '0;
    wdata_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_s    = wr_s | (wr_rd_i[c] & ready_s[c]);
      addr_s  = addr_s | (addr_i[c*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{ready_s[c]}});
      wdata_s = wdata_s | (wdata_i[c*WIDTH +: WIDTH] & {WIDTH{ready_s[c]}});
    end
  end

`ifdef MEM_WSTRB_EN
  localparam int NB = WIDTH / 8;
  logic [NB-1:0] strb_s;

  // Granted channel's byte strobes expanded to a bit mask.
  always_comb begin
    strb_s  = '0;
    wmask_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      strb_s = strb_s | (wstrb_i[c*NB +: NB] & {NB{ready_s[c]}});
    end
    for (int b = 0; b < NB; b++) begin
      wmask_s[b*8 +: 8] = {8{strb_s[b]}};
    end
  end
`else
  assign wmask_s = '1;
`endif

  // RAM array, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[addr_s] <= (mem_q[addr_s] & ~wmask_s) | (wdata_s & wmask_s);
    end
  end

  // Read pipeline; payload only moves with a valid entry so the outputs hold when idle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0].valid <= rd_en_s;
      if (rd_en_s) begin
        pipe_q[0].ch   <= MAX_CH_W'(gnt_idx_s);
        pipe_q[0].data <= MAX_WIDTH'(mem_q[addr_s]);
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i].valid <= pipe_q[i-1].valid;
        if (pipe_q[i-1].valid) begin
          pipe_q[i].ch   <= pipe_q[i-1].ch;
          pipe_q[i].data <= pipe_q[i-1].data;
        end
      end
    end
  end

  assign rvalid_o = pipe_q[RD_LAT-1].valid;
  assign rch_o    = pipe_q[RD_LAT-1].ch[CH_W-1:0];
  assign rdata_o  = pipe_q[RD_LAT-1].data[WIDTH-1:0];
  assign unused_s = ^pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_mc_arb.sv
// Directed bench for mem_mc_arb (2 channels, 16-bit data, read latency 3).
module tb_mem_mc_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  valid_i;
  logic [1:0]  wr_rd_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
`ifdef MEM_WSTRB_EN
  logic [3:0]  wstrb_i;
`endif
  logic [1:0]  ready_o;
  logic [15:0] rdata_o;
  logic        rvalid_o;
  logic        rch_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mem_mc_arb #(.WIDTH(16), .ADDR_WIDTH(4), .NUM_CH(2), .RD_LAT(3)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .wr_rd_i  (wr_rd_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
`ifdef MEM_WSTRB_EN
    .wstrb_i  (wstrb_i),
`endif
    .ready_o  (ready_o),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .rch_o    (rch_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [1:0] v, input logic [1:0] w, input logic [3:0] a1,
                     input logic [3:0] a0, input logic [15:0] d1, input logic [15:0] d0);
    valid_i = v;
    wr_rd_i = w;
    addr_i  = {a1, a0};
    wdata_i = {d1, d0};
    #1;
  endtask

  initial begin
`ifdef MEM_WSTRB_EN
    wstrb_i = 4'b1111;
`endif
    // reset: ready forced low, outputs cleared
    rst_i = 1'b0;
    req(2'b11, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    chk("rst_ready", 32'(ready_o), 32'h0);
    cyc();
    cyc();
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_rdata", 32'(rdata_o), 32'h0);
    chk("rst_rch", 32'(rch_o), 32'h0);
    rst_i = 1'b1;
    req(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);

    // ch0 write BEEF @3 then read back, latency 3
    req(2'b01, 2'b01, 4'd0, 4'd3, 16'h0, 16'hBEEF);
    chk("w1_ready", 32'(ready_o), 32'h1);
    cyc();
    req(2'b01, 2'b00, 4'd0, 4'd3, 16'h0, 16'h0);
    chk("r1_ready", 32'(ready_o), 32'h1);
    cyc();
    req(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    chk("r1_lat1", 32'(rvalid_o), 32'h0);
    cyc();
    chk("r1_lat2", 32'(rvalid_o), 32'h0);
    cyc();
    chk("r1_rvalid", 32'(rvalid_o), 32'h1);
    chk("r1_rdata", 32'(rdata_o), 32'hBEEF);
    chk("r1_rch", 32'(rch_o), 32'h0);
    cyc();
    chk("r1_pulse", 32'(rvalid_o), 32'h0);
    chk("r1_hold", 32'(rdata_o), 32'hBEEF);

    // preload: ch0 A1A1 @1, ch1 B2B2 @2 (pointer ends at 0)
    req(2'b01, 2'b01, 4'd0, 4'd1, 16'h0, 16'hA1A1);
    chk("pre0_ready", 32'(ready_o), 32'h1);
    cyc();
    req(2'b10, 2'b10, 4'd2, 4'd0, 16'hB2B2, 16'h0);
    chk("pre1_ready", 32'(ready_o), 32'h2);
    cyc();

    // contention: both read continuously for 4 cycles
    for (int i = 0; i < 7; i++) begin
      if (i < 4) req(2'b11, 2'b00, 4'd2, 4'd1, 16'h0, 16'h0);
      else       req(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
      chk("cont_ready", 32'(ready_o), (i < 4) ? ((i % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      cyc();
      chk("cont_rvalid", 32'(rvalid_o), (i >= 2 && i <= 5) ? 32'h1 : 32'h0);
      if (i >= 2 && i <= 5) begin
        chk("cont_rch", 32'(rch_o), 32'(i % 2));
        chk("cont_rdata", 32'(rdata_o), (i % 2 == 0) ? 32'hA1A1 : 32'hB2B2);
      end
    end

    // fairness: ch1, then ch0 alone, then ch1 alone, no idle cycles
    req(2'b10, 2'b00, 4'd2, 4'd0, 16'h0, 16'h0);
    chk("fair_ch1", 32'(ready_o), 32'h2);
    cyc();
    req(2'b01, 2'b00, 4'd0, 4'd1, 16'h0, 16'h0);
    chk("fair_ch0", 32'(ready_o), 32'h1);
    cyc();
    req(2'b10, 2'b00, 4'd2, 4'd0, 16'h0, 16'h0);
    chk("fair_ch1b", 32'(ready_o), 32'h2);
    cyc();
    req(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    chk("fair_rsp0_rch", 32'(rch_o), 32'h1);
    chk("fair_rsp0_data", 32'(rdata_o), 32'hB2B2);
    cyc();
    chk("fair_rsp1_v", 32'(rvalid_o), 32'h1);
    chk("fair_rsp1_rch", 32'(rch_o), 32'h0);
    chk("fair_rsp1_data", 32'(rdata_o), 32'hA1A1);
    cyc();
    chk("fair_rsp2_v", 32'(rvalid_o), 32'h1);
    chk("fair_rsp2_rch", 32'(rch_o), 32'h1);
    cyc();
    chk("fair_idle", 32'(rvalid_o), 32'h0);

    // read-after-write: ch1 writes 1234 @7, ch0 reads @7 next cycle
    req(2'b10, 2'b10, 4'd7, 4'd0, 16'h1234, 16'h0);
    chk("raw_w_ready", 32'(ready_o), 32'h2);
    cyc();
    req(2'b01, 2'b00, 4'd0, 4'd7, 16'h0, 16'h0);
    chk("raw_r_ready", 32'(ready_o), 32'h1);
    cyc();
    req(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cyc();
    cyc();
    chk("raw_rvalid", 32'(rvalid_o), 32'h1);
    chk("raw_rdata", 32'(rdata_o), 32'h1234);
    chk("raw_rch", 32'(rch_o), 32'h0);

    // partial write: strobed when enabled, full word otherwise
    req(2'b01, 2'b01, 4'd0, 4'd0, 16'h0, 16'hFFFF);
    chk("bw_w0_ready", 32'(ready_o), 32'h1);
    cyc();
`ifdef MEM_WSTRB_EN
    wstrb_i = 4'b0001;
`endif
    req(2'b01, 2'b01, 4'd0, 4'd0, 16'h0, 16'h00AA);
    cyc();
`ifdef MEM_WSTRB_EN
    wstrb_i = 4'b1111;
`endif
    req(2'b01, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cyc();
    req(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cyc();
    cyc();
    chk("bw_rvalid", 32'(rvalid_o), 32'h1);
`ifdef MEM_WSTRB_EN
    chk("bw_rdata", 32'(rdata_o), 32'hFFAA);
`else
    chk("bw_rdata", 32'(rdata_o), 32'h00AA);
`endif

    // reset one cycle after a read handshake: response dropped, pointer back to 0, RAM cleared
    req(2'b01, 2'b00, 4'd0, 4'd7, 16'h0, 16'h0);
    chk("mr_ready", 32'(ready_o), 32'h1);
    cyc();
    rst_i = 1'b0;
    req(2'b11, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    chk("mr_rst_ready", 32'(ready_o), 32'h0);
    chk("mr_rvalid0", 32'(rvalid_o), 32'h0);
    cyc();
    rst_i = 1'b1;
    req(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    chk("mr_rvalid1", 32'(rvalid_o), 32'h0);
    cyc();
    chk("mr_rvalid2", 32'(rvalid_o), 32'h0);
    cyc();
    chk("mr_rvalid3", 32'(rvalid_o), 32'h0);
    req(2'b11, 2'b00, 4'd7, 4'd7, 16'h0, 16'h0);
    chk("mr_first_grant", 32'(ready_o), 32'h1);
    cyc();
    req(2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cyc();
    cyc();
    chk("mr_post_rvalid", 32'(rvalid_o), 32'h1);
    chk("mr_post_rdata", 32'(rdata_o), 32'h0);
    chk("mr_post_rch", 32'(rch_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
